// File: rtl/mem_dump_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_dump_pkg                                                               |
// | Widths and FSM state encoding shared by the memory dumper, mem and mux.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_dump_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_SEND = 3'd2,
        ST_SUM  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage : mem_dump_pkg
`default_nettype wire

// File: rtl/mem_dump_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_dump_if                                                                |
// | Memory read port plus valid/ready word stream of the memory dumper.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mem_dump_if
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output mem_addr, mem_we, out_data, out_valid, out_last,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_addr, mem_we, out_data, out_valid, out_last,
        output mem_rdata, out_ready
    );
endinterface : mem_dump_if
`default_nettype wire

// File: rtl/mem_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_dump                                                                   |
// | Walks a contiguous word range and streams it out over valid/ready.         |
// | MEM_DUMP_CHECKSUM_EN appends a 16-bit modular sum word to every dump.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_dump
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [ADDR_W-1:0] count,
    output logic                   busy,
    output logic                   done,
    mem_dump_if.master             bus
);

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [ADDR_W-1:0] rem_q,       rem_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;
    logic              handshake;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q,       sum_d;
`endif

    assign handshake = out_valid_q & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef MEM_DUMP_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = count;
`ifdef MEM_DUMP_CHECKSUM_EN
                    sum_d  = '0;
`endif
                    if (count == '0) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        out_data_d  = '0;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        state_d     = ST_SUM;
`else
                        state_d     = ST_FIN;
`endif
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                out_data_d  = bus.mem_rdata;
                out_valid_d = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
`else
                out_last_d  = (rem_q == ADDR_W'(1));
`endif
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    rem_d       = rem_q - ADDR_W'(1);
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
                    sum_d       = sum_q + out_data_q;
`endif
                    if (rem_q == ADDR_W'(1)) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        // Checksum word is staged now so SUM presents it immediately
                        out_data_d  = sum_q + out_data_q;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        state_d     = ST_SUM;
`else
                        state_d     = ST_FIN;
`endif
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            ST_SUM: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_FIN;
                end
            end
`endif
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FIN);
    assign bus.mem_addr  = (state_q == ST_READ || state_q == ST_SEND) ? addr_q : '0;
    assign bus.mem_we    = 1'b0;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

endmodule : mem_dump
`default_nettype wire

// File: tb/tb_mem_dump.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_dump                                                                |
// | Scoreboard bench for mem_dump; honours MEM_DUMP_CHECKSUM_EN if defined.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_dump;
    import mem_dump_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] count = '0;
    logic          ready = 1'b1;
    logic          busy;
    logic          done;

    mem_dump_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:65535];
    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.out_ready = ready;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          chk_addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_done_cyc = -1;
    int   n_acc = 0;
    int   done_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: inputs change just after posedge, so negedge sees the values the next edge samples
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             bus.out_valid, bus.out_data, bus.out_last, prev_data, prev_last);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: data=%h, required no valid word", bus.out_data);
                end else if (bus.out_ready) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (bus.out_data !== e.data || bus.out_last !== e.last ||
                        (e.chk_addr && bus.mem_addr !== e.addr)) begin
                        errors++;
                        $display("FAIL word: data=%h last=%b addr=%h, required data=%h last=%b addr=%h",
                                 bus.out_data, bus.out_last, bus.mem_addr, e.data, e.last, e.addr);
                    end
                    n_acc++;
                    if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
                end
            end
            if (done) begin
                checks++;
                done_cnt++;
                if (cyc != exp_done_cyc) begin
                    errors++;
                    $display("FAIL done_timing: done in cycle %0d, required cycle %0d", cyc, exp_done_cyc);
                end
                exp_done_cyc = -1;
            end
        end
    end

    task automatic run_dump(input logic [AW-1:0] base, input logic [AW-1:0] n,
                            input int stall_word, input int stall_len);
        logic [DW-1:0] s;
        logic [AW-1:0] a;
        int            start_done;
        int            t;
        int            st;
        s = '0;
        for (int i = 0; i < int'(n); i++) begin
            a = AW'(int'(base) + i);
`ifdef MEM_DUMP_CHECKSUM_EN
            exp_q.push_back('{addr: a, chk_addr: 1'b1, data: mem[a], last: 1'b0});
`else
            exp_q.push_back('{addr: a, chk_addr: 1'b1, data: mem[a], last: (i == int'(n) - 1)});
`endif
            s = s + mem[a];
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_q.push_back('{addr: '0, chk_addr: 1'b0, data: s, last: 1'b1});
`endif
        n_acc      = 0;
        start_done = done_cnt;
        ready      = 1'b1;
        @(posedge clk); #1;
        base_addr = base;
        count     = n;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifndef MEM_DUMP_CHECKSUM_EN
        if (n == '0) exp_done_cyc = cyc;
`endif
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: busy=%b, required 1", busy);
        end
        // A start while busy must be ignored
        base_addr = 16'hDEAD;
        count     = 16'd7;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t  = 0;
        st = 0;
        while (done_cnt == start_done && t < 200) begin
            if (n_acc == stall_word && st < stall_len) begin
                ready = 1'b0;
                if (bus.out_valid) st++;
            end else begin
                ready = 1'b1;
            end
            @(posedge clk); #1;
            t++;
        end
        ready = 1'b1;
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL dump_timeout: no done within %0d cycles, required done", t);
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL dump_end: busy=%b pending=%0d, required busy=0 pending=0", busy, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.mem_addr !== '0 || bus.mem_we !== 1'b0 ||
            bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b addr=%h we=%b data=%h valid=%b last=%b, required all 0",
                     name, busy, done, bus.mem_addr, bus.mem_we, bus.out_data, bus.out_valid, bus.out_last);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_dump(16'h0010, 16'd4, -1, 0);
    endtask

    task automatic test_backpressure();
        run_dump(16'h0010, 16'd4, 1, 5);
    endtask

    task automatic test_wrap();
        run_dump(16'hFFFE, 16'd3, -1, 0);
    endtask

    task automatic test_zero_count();
        run_dump(16'h0050, 16'd0, -1, 0);
    endtask

    task automatic test_checksum();
        mem[16'h0020] = 16'h8000;
        mem[16'h0021] = 16'h8001;
        run_dump(16'h0020, 16'd2, -1, 0);
    endtask

    task automatic test_back_to_back();
        run_dump(16'h0100, 16'd2, -1, 0);
        run_dump(16'h0200, 16'd1, 0, 3);
    endtask

    task automatic test_mid_reset();
        int t;
        int d0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{addr: AW'(16'h0030 + i), chk_addr: 1'b1, data: mem[16'h0030 + i], last: (i == 3)});
        end
        n_acc = 0;
        d0    = done_cnt;
        ready = 1'b1;
        @(posedge clk); #1;
        base_addr = 16'h0030;
        count     = 16'd4;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!(n_acc == 1 && bus.out_valid) && t < 50) begin
            ready = (n_acc == 0);
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL mid_reset_reach: second word not presented, required valid");
        end
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_reset_outputs");
        exp_q.delete();
        exp_done_cyc = -1;
        @(posedge clk); #1;
        rst   = 1'b0;
        ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL mid_reset_no_done: done pulses=%0d, required %0d", done_cnt, d0);
        end
        run_dump(16'h0040, 16'd3, -1, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = DW'(32'h1000 + i);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_checksum();
        test_back_to_back();
        test_mid_reset();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_dump
`default_nettype wire

// File: doc/mem_dump.md
# mem_dump

Sequential memory reader: the read-side counterpart to the bench loader that fills `mem` while `rst` is held. On a `start` pulse it walks a contiguous range of the 16-bit word memory and streams each word out over a valid/ready interface, for program/data dumps and post-run result extraction. It sits beside `proc` on the shared memory port. The top-level mux grants it the port while `busy` is high.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory word width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, reset asynchronous and active-high
- start  in  1  begin dump; sampled only in IDLE
- base_addr  in  ADDR_W  first address, latched on accepted start
- count  in  ADDR_W  number of words to read, latched on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the dump completes
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable; tied 0
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr
- out_data  out  DATA_W  streamed word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts
- out_last  out  1  marks final word of the dump

## Operation
- States: IDLE, READ, SEND, SUM (only with macro), FIN.
- IDLE: if start=1, latch base_addr into addr_q and count into rem_q, then go to READ. If the latched count is 0, go to FIN instead (SUM with macro).
- READ: mem_addr=addr_q. Capture mem_rdata into out_data. Set out_valid. Go to SEND.
- SEND: hold out_data/out_valid/out_last stable while out_ready=0. On handshake (out_valid & out_ready), addr_q += 1 (mod 2^ADDR_W) and rem_q -= 1. If rem_q was 1, go to FIN (SUM with macro). Otherwise go to READ.
- FIN: done=1 for one cycle, then IDLE.
- out_last=1 on the final emitted word only.
- start while not IDLE is ignored.
- mem_addr = addr_q in READ/SEND, 0 otherwise.
- mem_we = 0 always.
- Address wraps 0xFFFF -> 0x0000 without error.

## Timing
- Reset values: busy=0, done=0, mem_addr=0, mem_we=0, out_data=0, out_valid=0, out_last=0. State is IDLE.
- Accepted start at edge N: READ during cycle N+1, out_valid=1 from edge N+2.
- Throughput: one word per 2 cycles with out_ready held 1.
- Back-pressure stalls SEND indefinitely with no change to any output.
- Final handshake at edge M: done=1 during cycle M+1 (M+2 with macro and immediate checksum acceptance); busy falls with done.
- rst mid-dump: all outputs return to reset values immediately. No done pulse. The partial dump is abandoned.

## Configuration
- MEM_DUMP_CHECKSUM_EN defined:
  - A 16-bit modular sum of all emitted data words is kept; it clears on accepted start.
  - After the last data word, SUM emits the checksum as one extra word with out_last=1, using the same handshake.
  - For count=0, a single checksum word 0x0000 is emitted.
- Not defined: no SUM state. out_last is on the final data word. count=0 emits nothing; done pulses the cycle after start.

## Structure
- Package mem_dump_pkg: state enum typedef, ADDR_W/DATA_W defaults shared with `mem` and the driver mux.
- Single flat module; no sub-module warranted (checksum is one adder and register).

## Test plan
- Memory preloaded with 0x1000+i at address i; start with base=0x0010, count=4, out_ready=1 -> words 0x1010..0x1013, out_last on 0x1013, done one cycle after the last handshake.
- Same dump with out_ready low for 5 cycles on the second word -> 0x1011 held stable throughout the stall, no duplicate or skipped words.
- base=0xFFFE, count=3 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000.
- count=0 -> no out_valid, done pulse; with macro, single word 0x0000 with out_last.
- Macro defined, words 0x8000, 0x8001 -> third word 0x0001 (modular sum) with out_last.
- rst asserted during SEND of word 2 of 4 -> outputs zero immediately, no done; a fresh start afterwards dumps correctly from its new base.
